// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the TX FIFO, the APB register block and uart_tx.
// The master side is the environment (register block plus transmitter); the FIFO is the slave.
interface uart_tx_fifo_if #(
    parameter int PTR_W = 4
);
    logic             wr_en_i;
    logic [7:0]       wr_data_i;
    logic             flush_i;
    logic             ovf_clr_i;
    logic             tx_en_i;
    logic             full_o;
    logic             empty_o;
    logic [PTR_W:0]   count_o;
    logic             overflow_o;
    logic             busy_o;
    logic [31:0]      tx_data_o;
    logic             start_tx_o;
    logic             tx_start_ack_i;
    logic             tx_done_i;

    modport master (
        output wr_en_i, wr_data_i, flush_i, ovf_clr_i, tx_en_i, tx_start_ack_i, tx_done_i,
        input  full_o, empty_o, count_o, overflow_o, busy_o, tx_data_o, start_tx_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, flush_i, ovf_clr_i, tx_en_i, tx_start_ack_i, tx_done_i,
        output full_o, empty_o, count_o, overflow_o, busy_o, tx_data_o, start_tx_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular TX byte FIFO feeding uart_tx one frame at a time over start/ack/done.
// The popped byte is held on tx_data_o for the whole frame since uart_tx samples it combinationally.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
    logic [PTR_W:0]   count_r, count_s;
    state_t           state_r, state_s;
    logic             pop_s, push_s, drop_s, ovf_s;
    logic             full_r, empty_r, overflow_r, busy_r, start_r;
    logic [7:0]       byte_r;

    // Frame sequencer: one pop per IDLE->REQ, start held until ack, then wait for done.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.tx_en_i && !empty_r && bus.tx_done_i && !bus.flush_i) begin
                    pop_s   = 1'b1;
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (bus.tx_start_ack_i) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Queue bookkeeping; a pop frees a slot, so a push into a full FIFO on a pop cycle is accepted.
    always_comb begin
        push_s   = bus.wr_en_i && (!full_r || pop_s) && !bus.flush_i;
        drop_s   = bus.wr_en_i && full_r && !pop_s;
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (bus.flush_i) begin
            wr_ptr_s = PTR_ZERO;
            rd_ptr_s = PTR_ZERO;
            count_s  = CNT_ZERO;
        end else begin
            wr_ptr_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end
        if (drop_s) begin
            ovf_s = 1'b1;
        end else if (bus.ovf_clr_i) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = overflow_r;
        end
    end

    // State, pointers and registered flags derived from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            start_r    <= 1'b0;
            byte_r     <= 8'h00;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            full_r     <= (count_s == FULL_CNT);
            empty_r    <= (count_s == CNT_ZERO);
            overflow_r <= ovf_s;
            busy_r     <= (state_s != IDLE) || (count_s != CNT_ZERO);
            start_r    <= (state_s == REQ);
            if (pop_s) begin
                byte_r <= mem_r[rd_ptr_r];
            end else begin
                byte_r <= byte_r;
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data_i;
        end
    end

    assign bus.full_o     = full_r;
    assign bus.empty_o    = empty_r;
    assign bus.count_o    = count_r;
    assign bus.overflow_o = overflow_r;
    assign bus.busy_o     = busy_r;
    assign bus.start_tx_o = start_r;
    assign bus.tx_data_o  = {24'h000000, byte_r};
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed pushes enqueue expected bytes, and a
// transmitter model/monitor checks every issued frame against that queue.
module tb_uart_tx_fifo;
    localparam int FRAME = 6;

    logic clk = 1'b0;
    logic reset;
    logic cts;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] cur_data;
    logic        in_frame;
    logic        prev_start;
    int          cnt;

    uart_tx_fifo_if #(.PTR_W(4)) bus ();

    uart_tx_fifo #(.DEPTH(16), .PTR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_tx);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = b;
        if (expect_tx) exp_q.push_back(b);
        tick();
        bus.wr_en_i = 1'b0;
    endtask

    task automatic wait_acked(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.tx_done_i && !bus.start_tx_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("ack_wait_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy_o && bus.tx_done_i && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("idle_wait_timeout", {31'd0, ok}, 32'd1);
    endtask

    // Transmitter model plus frame monitor, evaluated away from the active edge.
    initial begin
        bus.tx_start_ack_i = 1'b0;
        bus.tx_done_i      = 1'b1;
        in_frame   = 1'b0;
        prev_start = 1'b0;
        cnt        = 0;
        cur_data   = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.tx_start_ack_i = 1'b0;
                bus.tx_done_i      = 1'b1;
                in_frame   = 1'b0;
                prev_start = 1'b0;
                cnt        = 0;
            end else begin
                if (bus.start_tx_o && !prev_start) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", bus.tx_data_o, 32'hFFFFFFFF);
                    end else begin
                        check("frame_data", bus.tx_data_o, {24'h000000, exp_q.pop_front()});
                        check("start_while_done_low", {31'd0, bus.tx_done_i}, 32'd1);
                    end
                    cur_data = bus.tx_data_o;
                    in_frame = 1'b1;
                end else if (in_frame) begin
                    check("data_stable", bus.tx_data_o, cur_data);
                end
                prev_start = bus.start_tx_o;
                if (bus.tx_start_ack_i) begin
                    bus.tx_start_ack_i = 1'b0;
                end else if (bus.start_tx_o && cts && bus.tx_done_i) begin
                    bus.tx_start_ack_i = 1'b1;
                    bus.tx_done_i      = 1'b0;
                    cnt                = FRAME;
                end else if (!bus.tx_done_i) begin
                    if (cnt == 0) begin
                        bus.tx_done_i = 1'b1;
                        in_frame      = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        cts           = 1'b1;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = 8'h00;
        bus.flush_i   = 1'b0;
        bus.ovf_clr_i = 1'b0;
        bus.tx_en_i   = 1'b0;
        repeat (3) tick();
        check("rst_full",     {31'd0, bus.full_o},     32'd0);
        check("rst_empty",    {31'd0, bus.empty_o},    32'd1);
        check("rst_count",    {27'd0, bus.count_o},    32'd0);
        check("rst_overflow", {31'd0, bus.overflow_o}, 32'd0);
        check("rst_busy",     {31'd0, bus.busy_o},     32'd0);
        check("rst_tx_data",  bus.tx_data_o,           32'd0);
        check("rst_start",    {31'd0, bus.start_tx_o}, 32'd0);
        reset = 1'b0;
        tick();

        // Single byte latency
        bus.tx_en_i = 1'b1;
        push(8'hA5, 1'b1);
        check("single_empty_after_push", {31'd0, bus.empty_o},    32'd0);
        check("single_count_after_push", {27'd0, bus.count_o},    32'd1);
        check("single_start_early",      {31'd0, bus.start_tx_o}, 32'd0);
        tick();
        check("single_start",   {31'd0, bus.start_tx_o}, 32'd1);
        check("single_count_0", {27'd0, bus.count_o},    32'd0);
        check("single_data",    bus.tx_data_o,           32'h000000A5);
        check("single_busy",    {31'd0, bus.busy_o},     32'd1);
        wait_idle(100);
        check("single_busy_end", {31'd0, bus.busy_o}, 32'd0);

        // Back-to-back pushes
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        wait_idle(200);

        // Full and overflow with transmit disabled
        bus.tx_en_i = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        check("full_after_16",  {31'd0, bus.full_o},  32'd1);
        check("count_after_16", {27'd0, bus.count_o}, 32'd16);
        push(8'h10, 1'b0);
        check("overflow_set",     {31'd0, bus.overflow_o}, 32'd1);
        check("count_after_drop", {27'd0, bus.count_o},    32'd16);
        check("start_disabled",   {31'd0, bus.start_tx_o}, 32'd0);
        bus.ovf_clr_i = 1'b1;
        tick();
        bus.ovf_clr_i = 1'b0;
        check("overflow_cleared", {31'd0, bus.overflow_o}, 32'd0);
        bus.tx_en_i = 1'b1;
        wait_idle(1000);

        // Push into a full FIFO on the pop cycle
        bus.tx_en_i = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b1);
        bus.tx_en_i = 1'b1;
        push(8'h55, 1'b1);
        check("popfull_count",    {27'd0, bus.count_o},    32'd16);
        check("popfull_full",     {31'd0, bus.full_o},     32'd1);
        check("popfull_overflow", {31'd0, bus.overflow_o}, 32'd0);
        check("popfull_start",    {31'd0, bus.start_tx_o}, 32'd1);
        wait_idle(1000);

        // CTS stall: start held without ack
        cts = 1'b0;
        push(8'h3C, 1'b1);
        tick();
        bus.tx_en_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            check("cts_start_held", {31'd0, bus.start_tx_o}, 32'd1);
            tick();
        end
        check("cts_busy", {31'd0, bus.busy_o}, 32'd1);
        cts = 1'b1;
        wait_idle(100);
        bus.tx_en_i = 1'b1;

        // Flush during the first frame
        bus.tx_en_i = 1'b0;
        push(8'hD1, 1'b1);
        push(8'hD2, 1'b1);
        push(8'hD3, 1'b1);
        push(8'hD4, 1'b1);
        bus.tx_en_i = 1'b1;
        wait_acked(50);
        exp_q.delete();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush_count", {27'd0, bus.count_o}, 32'd0);
        check("flush_empty", {31'd0, bus.empty_o}, 32'd1);
        check("flush_busy",  {31'd0, bus.busy_o},  32'd1);
        check("flush_data",  bus.tx_data_o,        32'h000000D1);
        wait_idle(100);
        repeat (20) tick();
        check("flush_no_start", {31'd0, bus.start_tx_o}, 32'd0);
        check("flush_empty_end", {31'd0, bus.empty_o},   32'd1);

        // Reset during a frame
        bus.tx_en_i = 1'b0;
        push(8'hE1, 1'b1);
        push(8'hE2, 1'b1);
        push(8'hE3, 1'b1);
        push(8'hE4, 1'b1);
        bus.tx_en_i = 1'b1;
        wait_acked(50);
        exp_q.delete();
        reset = 1'b1;
        tick();
        check("mid_rst_full",     {31'd0, bus.full_o},     32'd0);
        check("mid_rst_empty",    {31'd0, bus.empty_o},    32'd1);
        check("mid_rst_count",    {27'd0, bus.count_o},    32'd0);
        check("mid_rst_overflow", {31'd0, bus.overflow_o}, 32'd0);
        check("mid_rst_busy",     {31'd0, bus.busy_o},     32'd0);
        check("mid_rst_tx_data",  bus.tx_data_o,           32'd0);
        check("mid_rst_start",    {31'd0, bus.start_tx_o}, 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        check("post_rst_start", {31'd0, bus.start_tx_o}, 32'd0);
        check("post_rst_busy",  {31'd0, bus.busy_o},     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer between the APB register block and uart_tx. Stores bytes written to the TX data register in a circular FIFO and feeds them one frame at a time to uart_tx through its start/ack/done handshake. Holds each byte stable on the transmitter's data input for the whole frame, because uart_tx samples tx_data_i combinationally in every data and parity bit slot.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
PTR_W, 4, log2(DEPTH); pointer width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en_i  in  1  push strobe from register block (one cycle per APB write to the TX data register)
wr_data_i  in  8  byte to push
flush_i  in  1  discard all queued entries
ovf_clr_i  in  1  clear the sticky overflow flag
tx_en_i  in  1  transmit enable from control register
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
count_o  out  PTR_W+1  number of queued entries, 0..DEPTH
overflow_o  out  1  sticky: a push was dropped
busy_o  out  1  high when a frame is in progress or the FIFO is non-empty
tx_data_o  out  32  to uart_tx tx_data_i; {24'b0, byte}
start_tx_o  out  1  to uart_tx start_tx_i
tx_start_ack_i  in  1  from uart_tx tx_start_ack_o
tx_done_i  in  1  from uart_tx tx_done_o

Behaviour:
- Reset values: full_o=0, empty_o=1, count_o=0, overflow_o=0, busy_o=0, tx_data_o=0, start_tx_o=0, state=IDLE. Pointers are 0. Reset mid-frame aborts immediately with no completion wait.
- Storage: DEPTH x 8 array. wr_ptr and rd_ptr are PTR_W bits wide, wrap modulo DEPTH. count is tracked separately. full_o = (count==DEPTH). empty_o = (count==0). All flags are registered.
- Push: accepted when wr_en_i && (!full || pop in the same cycle). An accepted push writes mem[wr_ptr] and increments wr_ptr.
- Dropped push: wr_en_i while full with no pop leaves the FIFO unchanged and sets overflow_o.
- overflow_o clears on ovf_clr_i. If a set and a clear occur in the same cycle, set wins.
- Pop: occurs only on the IDLE->REQ transition. Latches mem[rd_ptr] into tx_data_o[7:0] and increments rd_ptr.
- Count update: push only gives +1, pop only gives -1, push and pop together leave count unchanged.
- Flush: flush_i zeroes the pointers and count on the next edge and takes priority over a same-cycle push or pop. A frame already handed to uart_tx (REQ/WAIT_DONE) completes normally. tx_data_o is held.
- FSM, IDLE:
  - Condition to leave: tx_en_i && !empty_o && tx_done_i && !flush_i.
  - On that condition: pop, set start_tx_o=1, go to REQ.
- FSM, REQ:
  - start_tx_o is held high until tx_start_ack_i is sampled high.
  - On ack: start_tx_o=0 and go to WAIT_DONE on the same edge.
  - start_tx_o is never dropped before ack; the transmitter acks only when CTS is asserted.
  - tx_en_i going low in REQ is ignored; the frame is committed.
- FSM, WAIT_DONE:
  - uart_tx drops tx_done_i on the edge it acks.
  - Stay in WAIT_DONE until tx_done_i==1, then go to IDLE.
  - The next pop can occur at the earliest one cycle after returning to IDLE, so exactly one start is issued per frame.
- tx_data_o changes only on a pop and is stable from the pop until the next pop.
- Latency: wr_en_i sampled at edge k into an empty FIFO, with tx_en_i=1 and the transmitter idle, gives empty_o=0 after edge k and start_tx_o=1 after edge k+1.
- busy_o = (state!=IDLE) || !empty_o, registered from next-state values.
- Disabling: tx_en_i=0 in IDLE holds the queue contents; no start is issued.

Test Plan:
- Single byte: reset, tx_en_i=1, push 0xA5. Required: start_tx_o high 2 edges after the push and held until the ack. tx_data_o=0x000000A5 through the frame. count_o goes 1->0 at the pop. busy_o drops after tx_done_i returns high.
- Back-to-back: push 0x11,0x22,0x33 on consecutive cycles. Required: three frames in order 0x11,0x22,0x33, one start per frame, none issued while tx_done_i=0, tx_data_o unchanged mid-frame.
- Full/overflow: tx_en_i=0, push 17 bytes (0x00..0x10). Required: full_o=1 after the 16th push, the 17th is dropped, overflow_o=1, count_o=16. Pulse ovf_clr_i and check overflow_o=0. Enable and check frames 0x00..0x0F with 0x10 absent.
- Push while full with a simultaneous pop: fill 16 entries, raise tx_en_i, push 0x55 on the pop cycle. Required: push accepted, count_o stays 16, 0x55 transmitted last.
- CTS stall: hold the transmitter's CTS deasserted so no ack arrives for 50 cycles. Required: start_tx_o stays high and the FSM stays in REQ. After CTS is released, the ack arrives and the frame completes.
- Flush and reset mid-operation:
  - Queue 4 bytes, flush_i during the first frame's WAIT_DONE. Required: the first frame completes, then empty_o=1 with no further starts.
  - Repeat with reset instead of flush. Required: all outputs at reset values on the next edge.
